// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
//   Host-side word handshake for uart_tx_engine.
//   The host presents a word with data_valid. The engine takes it on any
//   posedge where data_valid and data_ready are both high.
//
//   Optional feature macro: UART_TX_PARITY_EN adds the parity_odd signal.
//
// Signals
//   data_in     host -> engine  WORD_SIZE  word to transmit
//   data_valid  host -> engine  1          data_in holds a word
//   data_ready  engine -> host  1          engine can accept a word this cycle
//   parity_odd  host -> engine  1          1 = odd parity, 0 = even (with macro only)
//
// Modports
//   master  host side (drives data_in, data_valid and parity_odd)
//   slave   engine side (drives data_ready)
// -----------------------------------------------------------------------------
interface uart_tx_engine_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;
`ifdef UART_TX_PARITY_EN
  logic                 parity_odd;

  modport master (output data_in, output data_valid, output parity_odd, input data_ready);
  modport slave  (input data_in, input data_valid, input parity_odd, output data_ready);
`else
  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
`endif
endinterface

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//   UART transmitter. It contains the word shadow register, the baud timing and
//   the frame FSM. A word accepted on the tx_if handshake is sent LSB-first as:
//     start(0), WORD_SIZE data bits, [parity], STOP_BITS stop bits(1).
//   Each bit lasts CLKS_PER_BIT clocks. If a new word is accepted in the last
//   stop cycle, the next frame starts with no idle gap.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a PARITY bit follows DATA. The bit is ^word ^ parity_odd.
//                  parity_odd is sampled on the handshake.
//     undefined -> DATA goes directly to STOP.
//
// Parameters
//   WORD_SIZE     data bits per frame, 5..9
//   CLKS_PER_BIT  clocks per serial bit, >= 1
//   STOP_BITS     stop bits, 1 or 2
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   tx_if       slave modport: data_in / data_valid / data_ready [/ parity_odd]
//   serial_out  out  TX line, registered, idle high
//   busy        out  frame in progress (state is not IDLE)
//   tx_done     out  one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_engine_if.slave   tx_if,
  output logic              serial_out,
  output logic              busy,
  output logic              tx_done
);

  // One counter is shared by all bit periods. Its longest run is the stop
  // period, so it is sized for that with one spare bit.
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS) + 1;
  localparam int IW = $clog2(WORD_SIZE) + 1;

  localparam logic [CW-1:0]        BIT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        STOP_MAX = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IW-1:0]        IDX_MAX  = IW'(WORD_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] BIT0     = WORD_SIZE'(1);

  if (WORD_SIZE < 5 || WORD_SIZE > 9) begin : g_bad_word_size
    $error("uart_tx_engine: WORD_SIZE must be 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_engine: CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_engine: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WORD_SIZE-1:0] shadow_q, shadow_d;
  logic                 serial_q, serial_d;
`ifdef UART_TX_PARITY_EN
  logic                 podd_q, podd_d;
`endif

  logic ready;
  logic accept;
  logic last_bit;
  logic last_stop;

  assign last_bit  = (cnt_q == BIT_MAX);
  assign last_stop = (state_q == S_STOP) && (cnt_q == STOP_MAX);

  // The engine is ready when idle and also in the final stop cycle, which
  // allows back-to-back frames. Reset blocks acceptance and the done pulse,
  // so a frame cut short by reset never reports completion.
  assign ready          = ~rst & ((state_q == S_IDLE) | last_stop);
  assign accept         = ready & tx_if.data_valid;
  assign tx_if.data_ready = ready;

  assign serial_out = serial_q;
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = ~rst & last_stop;

  always_comb begin
    // NOTE: every signal written here is given a default before the case
    // statement. No path can then keep an old value, so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
    podd_d   = podd_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (last_bit) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (last_bit) begin
          cnt_d = '0;
          if (idx_q == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last_bit) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (last_stop) begin
          cnt_d   = '0;
          state_d = accept ? S_START : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      shadow_d = tx_if.data_in;
`ifdef UART_TX_PARITY_EN
      podd_d   = tx_if.parity_odd;
`endif
    end

    // The line value is computed from the next state and registered. The pin
    // is then glitch-free, and it changes on the edge that enters each bit.
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = |(shadow_d & (BIT0 << idx_d));
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = (^shadow_d) ^ podd_d;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  // NOTE: registers use non-blocking assignments. All of them then update
  // together at the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
    end
  end

  // NOTE: the word registers are datapath only and have no reset. They are
  // always loaded on a handshake before they are read.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
`ifdef UART_TX_PARITY_EN
    podd_q   <= podd_d;
`endif
  end

endmodule
